// File: rtl/ecc_scrub_sched_if.sv
// Scrubber-facing handshake of the ECC scrub scheduler: the trigger pulse
// going out, the interconnect busy hint and the scrubber's result flags coming in.
interface ecc_scrub_sched_if;
  logic scrub_trigger_o;
  logic intc_busy_i;
  logic bit_corrected_i;
  logic uncorrectable_i;

  // Scheduler side
  modport master (
    output scrub_trigger_o,
    input  intc_busy_i,
    input  bit_corrected_i,
    input  uncorrectable_i
  );

  // Scrubber / interconnect side
  modport slave (
    input  scrub_trigger_o,
    output intc_busy_i,
    output bit_corrected_i,
    output uncorrectable_i
  );
endinterface

// File: rtl/ecc_scrub_sched.sv
// ECC scrub scheduler: issues rate-limited scrub trigger pulses while the
// cache interconnect is idle, mirrors the scrubber's way/index walk and keeps
// saturating error/sweep statistics with a sticky level interrupt.
// Optional error log (first uncorrectable position) enabled by the macro
// ECC_SCRUB_ERRLOG_EN; without it the log outputs are tied to zero.
module ecc_scrub_sched #(
  parameter int IntervalWidth    = 16,
  parameter int CntWidth         = 16,
  parameter int BankSize         = 256,
  parameter int AddrWidth        = 8,
  parameter int DCACHE_SET_ASSOC = 2,
  localparam int WayWidth = (DCACHE_SET_ASSOC > 1) ? $clog2(DCACHE_SET_ASSOC) : 1
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  ecc_scrub_sched_if.master        scrub_if,
  input  logic                     enable_i,
  input  logic [IntervalWidth-1:0] interval_i,
  input  logic [CntWidth-1:0]      threshold_i,
  input  logic                     clear_i,
  output logic [CntWidth-1:0]      corr_cnt_o,
  output logic [CntWidth-1:0]      uncorr_cnt_o,
  output logic [CntWidth-1:0]      sweep_cnt_o,
  output logic [AddrWidth-1:0]     cur_index_o,
  output logic [WayWidth-1:0]      cur_way_o,
  output logic                     irq_o,
  output logic                     err_valid_o,
  output logic [AddrWidth-1:0]     err_index_o,
  output logic [WayWidth-1:0]      err_way_o
);

  // The scrubber needs at least 8 cycles to return to Idle between pulses.
  localparam logic [IntervalWidth-1:0] MinInterval = IntervalWidth'(8);
  localparam logic [WayWidth-1:0]      LastWay     = WayWidth'(DCACHE_SET_ASSOC - 1);
  localparam logic [AddrWidth-1:0]     LastIndex   = AddrWidth'(BankSize - 1);

  typedef enum logic [1:0] {
    S_DISABLED,
    S_COUNT,
    S_PENDING,
    S_FIRE
  } state_e;

  state_e                   state_q, state_d;
  logic [IntervalWidth-1:0] cnt_q, cnt_d;
  logic                     trigger_q, trigger_d;
  logic [IntervalWidth-1:0] eff_interval;
  logic [IntervalWidth-1:0] reload;

  logic [WayWidth-1:0]      way_q, way_d;
  logic [AddrWidth-1:0]     index_q, index_d;
  logic                     sweep_done;

  logic [CntWidth-1:0]      corr_q, corr_d;
  logic [CntWidth-1:0]      uncorr_q, uncorr_d;
  logic [CntWidth-1:0]      sweep_q, sweep_d;
  logic                     irq_q, irq_d;

  logic fire;
  logic busy;
  logic corr_ev;
  logic uncorr_ev;

  assign busy      = scrub_if.intc_busy_i;
  assign corr_ev   = scrub_if.bit_corrected_i;
  assign uncorr_ev = scrub_if.uncorrectable_i;
  assign fire      = (state_q == S_FIRE);

  assign eff_interval = (interval_i < MinInterval) ? MinInterval : interval_i;
  assign reload       = eff_interval - 1'b1;

  function automatic logic [CntWidth-1:0] sat_inc(input logic [CntWidth-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Trigger FSM: next state, interval counter and registered trigger pulse
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!enable_i) begin
      state_d = S_DISABLED;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        S_DISABLED: begin
          state_d = S_COUNT;
          cnt_d   = reload;
        end
        S_COUNT: begin
          if (cnt_q == '0) begin
            state_d = busy ? S_PENDING : S_FIRE;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        S_PENDING: begin
          if (!busy) state_d = S_FIRE;
        end
        S_FIRE: begin
          state_d = S_COUNT;
          cnt_d   = reload;
        end
        default: state_d = S_DISABLED;
      endcase
    end
    trigger_d = (state_d == S_FIRE);
  end

  // FSM state, interval counter and trigger register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_DISABLED;
      cnt_q     <= '0;
      trigger_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      trigger_q <= trigger_d;
    end
  end

  // Walk position: way-major within an index, advanced as the FIRE cycle ends
  always_comb begin
    way_d      = way_q;
    index_d    = index_q;
    sweep_done = 1'b0;
    if (fire) begin
      if (way_q == LastWay) begin
        way_d = '0;
        if (index_q == LastIndex) begin
          index_d    = '0;
          sweep_done = 1'b1;
        end else begin
          index_d = index_q + 1'b1;
        end
      end else begin
        way_d = way_q + 1'b1;
      end
    end
  end

  // Position registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      way_q   <= '0;
      index_q <= '0;
    end else begin
      way_q   <= way_d;
      index_q <= index_d;
    end
  end

  // Statistics and interrupt; clear beats any event arriving in the same cycle
  always_comb begin
    corr_d   = corr_q;
    uncorr_d = uncorr_q;
    sweep_d  = sweep_q;
    irq_d    = irq_q;
    if (clear_i) begin
      corr_d   = '0;
      uncorr_d = '0;
      sweep_d  = '0;
      irq_d    = 1'b0;
    end else begin
      if (corr_ev)    corr_d   = sat_inc(corr_q);
      if (uncorr_ev)  uncorr_d = sat_inc(uncorr_q);
      if (sweep_done) sweep_d  = sat_inc(sweep_q);
      if (uncorr_ev) irq_d = 1'b1;
      if (corr_ev && (threshold_i != '0) && (corr_d >= threshold_i)) irq_d = 1'b1;
    end
  end

  // Statistics registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      corr_q   <= '0;
      uncorr_q <= '0;
      sweep_q  <= '0;
      irq_q    <= 1'b0;
    end else begin
      corr_q   <= corr_d;
      uncorr_q <= uncorr_d;
      sweep_q  <= sweep_d;
      irq_q    <= irq_d;
    end
  end

`ifdef ECC_SCRUB_ERRLOG_EN
  logic [WayWidth-1:0]  last_way_q;
  logic [AddrWidth-1:0] last_index_q;
  logic                 fired_q;
  logic                 log_valid_q;
  logic [WayWidth-1:0]  log_way_q;
  logic [AddrWidth-1:0] log_index_q;

  // Remember the position of the most recent trigger for error attribution
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_way_q   <= '0;
      last_index_q <= '0;
      fired_q      <= 1'b0;
    end else if (fire) begin
      last_way_q   <= way_q;
      last_index_q <= index_q;
      fired_q      <= 1'b1;
    end
  end

  // Capture the first uncorrectable error position; later errors never overwrite
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      log_valid_q <= 1'b0;
      log_way_q   <= '0;
      log_index_q <= '0;
    end else if (clear_i) begin
      log_valid_q <= 1'b0;
      log_way_q   <= '0;
      log_index_q <= '0;
    end else if (uncorr_ev && fired_q && !log_valid_q) begin
      log_valid_q <= 1'b1;
      log_way_q   <= last_way_q;
      log_index_q <= last_index_q;
    end
  end

  assign err_valid_o = log_valid_q;
  assign err_way_o   = log_way_q;
  assign err_index_o = log_index_q;
`else
  assign err_valid_o = 1'b0;
  assign err_way_o   = '0;
  assign err_index_o = '0;
`endif

  assign scrub_if.scrub_trigger_o = trigger_q;
  assign corr_cnt_o   = corr_q;
  assign uncorr_cnt_o = uncorr_q;
  assign sweep_cnt_o  = sweep_q;
  assign cur_index_o  = index_q;
  assign cur_way_o    = way_q;
  assign irq_o        = irq_q;

endmodule

// File: tb/tb_ecc_scrub_sched.sv
// Directed bench for ecc_scrub_sched: trigger timing, busy hold-off,
// walk order, statistics, interrupt, clear, saturation and error log.
module tb_ecc_scrub_sched;
  localparam int IW   = 16;
  localparam int CW   = 4;
  localparam int BS   = 4;
  localparam int AW   = 2;
  localparam int WAYS = 2;
  localparam int WW   = 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable;
  logic [IW-1:0] interval;
  logic [CW-1:0] threshold;
  logic          clear;
  logic [CW-1:0] corr_cnt, uncorr_cnt, sweep_cnt;
  logic [AW-1:0] cur_index, err_index;
  logic [WW-1:0] cur_way, err_way;
  logic          irq, err_valid;

  int n_cmp = 0;
  int n_err = 0;
  int trig_total = 0;

  always #5 clk = ~clk;

  ecc_scrub_sched_if sif ();

  ecc_scrub_sched #(
    .IntervalWidth(IW), .CntWidth(CW), .BankSize(BS),
    .AddrWidth(AW), .DCACHE_SET_ASSOC(WAYS)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .scrub_if(sif),
    .enable_i(enable), .interval_i(interval), .threshold_i(threshold),
    .clear_i(clear), .corr_cnt_o(corr_cnt), .uncorr_cnt_o(uncorr_cnt),
    .sweep_cnt_o(sweep_cnt), .cur_index_o(cur_index), .cur_way_o(cur_way),
    .irq_o(irq), .err_valid_o(err_valid), .err_index_o(err_index),
    .err_way_o(err_way)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts edges until the trigger is seen high; n = -1 if none within budget.
  task automatic next_trig(output int n);
    bit seen;
    seen = 1'b0;
    n = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      n++;
      if (sif.scrub_trigger_o) begin
        seen = 1'b1;
        break;
      end
    end
    if (seen) trig_total++;
    else n = -1;
  endtask

  initial begin
    int n;
    int pre;
    int pulses;
    enable = 0; interval = 16'd20; threshold = '0; clear = 0;
    sif.intc_busy_i = 0; sif.bit_corrected_i = 0; sif.uncorrectable_i = 0;

    // Reset state
    repeat (2) tick();
    check("rst_trigger", {31'd0, sif.scrub_trigger_o}, 0);
    check("rst_corr", corr_cnt, 0);
    check("rst_irq", {31'd0, irq}, 0);
    check("rst_index", cur_index, 0);
    check("rst_errvalid", {31'd0, err_valid}, 0);
    rst_n = 1;
    tick();

    // interval 20: first pulse 20 cycles after enable is sampled, then every 21;
    // walk order (way,index) and error injection after triggers 5 and 6.
    enable = 1;
    tick();
    pre = 0;
    for (int k = 0; k < 8; k++) begin
      next_trig(n);
      check($sformatf("period_%0d", k), n, (k == 0) ? 20 : 21 - pre);
      check($sformatf("walk_way_%0d", k), cur_way, k % 2);
      check($sformatf("walk_idx_%0d", k), cur_index, k / 2);
      pre = 0;
      if (k == 0) begin
        tick();
        check("pulse_width", {31'd0, sif.scrub_trigger_o}, 0);
        pre = 1;
      end
      if (k == 5 || k == 6) begin
        tick();
        sif.uncorrectable_i = 1;
        tick();
        sif.uncorrectable_i = 0;
        pre = 2;
      end
    end
    tick();
    check("sweep_cnt", sweep_cnt, 1);
    check("wrap_index", cur_index, 0);
    check("wrap_way", cur_way, 0);
    check("uncorr_cnt", uncorr_cnt, 2);
    check("irq_uncorr", {31'd0, irq}, 1);
`ifdef ECC_SCRUB_ERRLOG_EN
    check("log_valid", {31'd0, err_valid}, 1);
    check("log_way", err_way, 1);
    check("log_index", err_index, 2);
`else
    check("log_valid_off", {31'd0, err_valid}, 0);
    check("log_index_off", err_index, 0);
`endif

    // Clear
    clear = 1; tick(); clear = 0;
    check("clr_uncorr", uncorr_cnt, 0);
    check("clr_sweep", sweep_cnt, 0);
    check("clr_irq", {31'd0, irq}, 0);
    check("clr_errvalid", {31'd0, err_valid}, 0);

    // Threshold 3
    threshold = 4'd3;
    sif.bit_corrected_i = 1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      check($sformatf("thr_corr_%0d", i), corr_cnt, i);
      check($sformatf("thr_irq_%0d", i), {31'd0, irq}, (i == 3) ? 1 : 0);
    end
    clear = 1;
    tick();
    clear = 0; sif.bit_corrected_i = 0;
    check("clr_wins_corr", corr_cnt, 0);
    check("clr_wins_irq", {31'd0, irq}, 0);

    // Interval 3 clamps to 8 -> period 9 (applies from the next reload)
    interval = 16'd3;
    next_trig(n);
    next_trig(n);
    check("clamp_period_a", n, 9);
    next_trig(n);
    check("clamp_period_b", n, 9);

    // Busy held 50 cycles across the deadline
    sif.intc_busy_i = 1;
    pulses = 0;
    repeat (50) begin
      tick();
      if (sif.scrub_trigger_o) pulses++;
    end
    check("busy_no_pulse", pulses, 0);
    sif.intc_busy_i = 0;
    tick();
    check("busy_release_pulse", {31'd0, sif.scrub_trigger_o}, 1);
    if (sif.scrub_trigger_o) trig_total++;

    // Drop enable mid-COUNT; then saturate corr while disabled
    repeat (3) tick();
    enable = 0;
    threshold = '0;
    pulses = 0;
    sif.bit_corrected_i = 1;
    repeat (14) begin
      tick();
      if (sif.scrub_trigger_o) pulses++;
    end
    sif.bit_corrected_i = 0;
    check("sat_pre", corr_cnt, 14);
    sif.bit_corrected_i = 1;
    repeat (2) tick();
    sif.bit_corrected_i = 0;
    check("sat_top", corr_cnt, 15);
    repeat (30) begin
      tick();
      if (sif.scrub_trigger_o) pulses++;
    end
    check("disabled_no_pulse", pulses, 0);
    check("retained_corr", corr_cnt, 15);
    check("retained_way", cur_way, trig_total % 2);
    check("retained_idx", cur_index, (trig_total / 2) % 4);

    // Asynchronous reset mid-cycle
    #2 rst_n = 0;
    #1;
    check("async_rst_corr", corr_cnt, 0);
    check("async_rst_idx", cur_index, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
